// File: rtl/reg_file_if.sv
// Register-file access bus: two combinational read ports and one write port.
// The datapath (master) drives addresses and write data; the register file (slave) returns read data.
interface reg_file_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]    A1;
  logic [AW-1:0]    A2;
  logic [AW-1:0]    A3;
  logic             WE3;
  logic [WIDTH-1:0] WD3;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;

  modport master (output A1, A2, A3, WE3, WD3, input  RD1, RD2);
  modport slave  (input  A1, A2, A3, WE3, WD3, output RD1, RD2);
endinterface

// File: rtl/reg_file.sv
// MIPS three-port register file: two async reads, one sync write, $zero hardwired.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data onto the read ports.
module reg_file #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;

  // Writes to r0 are dropped so it clears on reset and never changes afterwards.
  assign wr_ok = bus.WE3 && (bus.A3 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.A3] <= bus.WD3;
    end
  end

  // Address 0 is forced to 0 so $zero reads clean even before the first reset.
  always_comb begin
    bus.RD1 = (bus.A1 == '0) ? '0 : regs[bus.A1];
    bus.RD2 = (bus.A2 == '0) ? '0 : regs[bus.A2];
`ifdef REGFILE_BYPASS_EN
    if (!rst && wr_ok && (bus.A1 == bus.A3)) bus.RD1 = bus.WD3;
    if (!rst && wr_ok && (bus.A2 == bus.A3)) bus.RD2 = bus.WD3;
`else
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected read data, a negedge monitor compares.
module tb_reg_file;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file_if #(.WIDTH(32), .AW(5)) bus ();

  reg_file #(.WIDTH(32), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Monitor: every queued entry is checked against the read ports at the next negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.RD1 !== e.e1) begin
        errors++;
        $display("FAIL %s RD1: got %h want %h", e.name, bus.RD1, e.e1);
      end
      checks++;
      if (bus.RD2 !== e.e2) begin
        errors++;
        $display("FAIL %s RD2: got %h want %h", e.name, bus.RD2, e.e2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.WE3 = 1'b1; bus.A3 = a; bus.WD3 = d;
    step();
    bus.WE3 = 1'b0;
  endtask

  task automatic rd(input string name, input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    bus.A1 = a1; bus.A2 = a2;
    e.name = name; e.e1 = e1; e.e2 = e2;
    q.push_back(e);
    step();
  endtask

  initial begin
    logic [31:0] coll_pre;
    rst = 1'b0;
    bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.WE3 = 1'b0; bus.WD3 = '0;
    #1;

    // $zero reads 0 before any reset
    rd("zero_prereset", 5'd0, 5'd0, 32'h0, 32'h0);

    rst = 1'b1; step(); rst = 1'b0;
    rd("after_reset", 5'd7, 5'd31, 32'h0, 32'h0);

    // Reset clears the array
    wr(5'd5, 32'hDEADBEEF);
    rd("r5_written", 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 32; i++)
      rd($sformatf("reset_sweep_%0d", i), 5'(i), 5'(31 - i), 32'h0, 32'h0);

    // Basic write/read on both ports
    wr(5'd8, 32'h12345678);
    wr(5'd31, 32'hFFFFFFFF);
    rd("basic", 5'd8, 5'd31, 32'h12345678, 32'hFFFFFFFF);
    rd("basic_swap", 5'd31, 5'd8, 32'hFFFFFFFF, 32'h12345678);

    // $zero is immutable
    wr(5'd0, 32'hAAAAAAAA);
    rd("zero_immut", 5'd0, 5'd0, 32'h0, 32'h0);

    // Write enable gating
    wr(5'd3, 32'h11);
    bus.WE3 = 1'b0; bus.A3 = 5'd3; bus.WD3 = 32'h99;
    step();
    rd("we_gate", 5'd3, 5'd3, 32'h11, 32'h11);

    // Same-cycle collision
    wr(5'd9, 32'h1);
`ifdef REGFILE_BYPASS_EN
    coll_pre = 32'h2;
`else
    coll_pre = 32'h1;
`endif
    bus.WE3 = 1'b1; bus.A3 = 5'd9; bus.WD3 = 32'h2;
    rd("collision_pre", 5'd9, 5'd9, coll_pre, coll_pre);
    bus.WE3 = 1'b0;
    rd("collision_post", 5'd9, 5'd9, 32'h2, 32'h2);

    // Reset beats a simultaneous write
    wr(5'd4, 32'h77);
    rd("r4_pre", 5'd4, 5'd8, 32'h77, 32'h12345678);
    rst = 1'b1; bus.WE3 = 1'b1; bus.A3 = 5'd4; bus.WD3 = 32'h55;
    step();
    rst = 1'b0; bus.WE3 = 1'b0;
    rd("reset_beats_write", 5'd4, 5'd8, 32'h0, 32'h0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file.md
# reg_file

Three-port MIPS general-purpose register file: two asynchronous read ports and one synchronous write port. It sits directly upstream of the ALU. Read port 1 drives `srcA`. Read port 2 drives the `srcB` mux and the data-memory write data. The write port takes the write-back value, which is either `ALUResult` or memory read data, selected by the `MemtoReg` mux.

## Interface
- `WIDTH`, 32, data width of every register and data port
- `DEPTH`, 32, number of registers; the address width is log2(DEPTH), which is 5 at the default
- `clk`  input  1  system clock; all state updates on the rising edge
- `rst`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`
- `A1`  input  5  read address, port 1 (rs)
- `A2`  input  5  read address, port 2 (rt)
- `A3`  input  5  write address (rt or rd, selected upstream by `RegDst`)
- `WE3`  input  1  write enable
- `WD3`  input  WIDTH  write data (write-back result)
- `RD1`  output  WIDTH  read data, port 1 (to ALU `srcA`)
- `RD2`  output  WIDTH  read data, port 2 (to `srcB` mux and data memory)

## Operation
- Storage is an array of `DEPTH` words, `regs[0..DEPTH-1]`.
- **Reset**
  - When `rst`=1 at a rising edge, every register clears to 0 in that single cycle.
  - `WE3` is ignored during that cycle; reset wins over a simultaneous write.
- **Write**
  - When `rst`=0 and `WE3`=1 at a rising edge, `regs[A3]` takes the value of `WD3`.
  - When `A3`=0, the write is discarded and `regs[0]` stays 0. `$zero` is hardwired.
  - When `WE3`=0, no register changes, whatever the values of `A3` and `WD3`.
- **Read**
  - Reads are combinational: `RD1` = `regs[A1]`, `RD2` = `regs[A2]`.
  - Address 0 always reads 0.
  - `A1` = `A2` is legal; both ports return the same value.
- **Reset values of outputs**
  - After the reset edge, `RD1` = `RD2` = 0 for every address until the first write.
  - Before the first reset, register contents are undefined (X in simulation). Reads from address 0 return 0 even then.
- **Width rules**
  - There is no sign or zero extension inside this block.
  - `WD3` is stored bit-for-bit.

## Timing
- Write latency is one edge. A value presented on `WD3` with `WE3`=1 before edge N appears on `RD1`/`RD2` after edge N. Without the bypass option, that is the first cycle in which it can be read.
- Read latency is zero cycles, i.e. a combinational path from `A1`/`A2` to `RD1`/`RD2`.
- **Same-cycle read and write to the same address** (`A1` or `A2` equal to `A3`, `WE3`=1, `A3`≠0):
  - Without the bypass option, the read returns the old value until the edge.
  - With the bypass option, see Configuration.
- **Reset asserted mid-program**
  - The write scheduled for that edge is lost.
  - All reads return 0 from the following cycle onward.
  - State held before the reset is not preserved.
- The block has no handshake and never stalls; every cycle is a valid read and write slot.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined:** write-to-read forwarding is compiled in.
  - When `WE3`=1, `rst`=0, `A3`≠0 and `A1`==`A3`, `RD1` = `WD3` in the same cycle. `RD2` behaves the same way for `A2`.
  - The address-0 rule and the reset rule still take precedence: `A3`=0 never forwards, and `rst`=1 suppresses forwarding.
  - This adds a combinational path from `WD3` to `RD1`/`RD2`.
- **Undefined:** reads strictly reflect the stored array. There is no combinational path from `WD3` to `RD1`/`RD2`.

## Test plan
- **Reset clears the array.** Write 0xDEADBEEF to r5, then pulse `rst` for one cycle. Sweep `A1` over 0..31. Required: `RD1`=0 at every address.
- **Basic write and read on both ports.** Write 0x12345678 to r8 and 0xFFFFFFFF to r31. Read `A1`=8, `A2`=31. Required: `RD1`=0x12345678, `RD2`=0xFFFFFFFF.
- **`$zero` is immutable.** Write 0xAAAAAAAA to r0 with `WE3`=1, then read `A1`=`A2`=0. Required: `RD1`=`RD2`=0.
- **Write enable gating.** With r3 = 0x11, drive `WE3`=0, `A3`=3, `WD3`=0x99 for one edge. Required: `RD1`(A1=3) = 0x11.
- **Same-cycle collision.** With r9 = 0x1, drive `WE3`=1, `A3`=9, `WD3`=0x2 and `A1`=`A2`=9, then sample before the edge.
  - Required without `REGFILE_BYPASS_EN`: `RD1`=`RD2`=0x1 before the edge.
  - Required with `REGFILE_BYPASS_EN`: `RD1`=`RD2`=0x2 before the edge.
  - Required in both builds: 0x2 after the edge.
- **Reset beats write.** Assert `rst`=1 with `WE3`=1, `A3`=4, `WD3`=0x55 on the same edge. Required: r4 reads 0 afterwards.
